// File: rtl/branch_predictor_unit.sv
// ============================================================================
// Module   : branch_predictor_unit
// Brief    : 8-entry direct-mapped bimodal predictor with branch target buffer
//            and saturating statistics counters. Optional tag/valid checking
//            is enabled by defining BPU_TAG_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor_unit #(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] PC_curr,
  input  logic [15:0] IF_ID_PC_curr,
  input  logic        wen_BHT,
  input  logic        wen_BTB,
  input  logic        actual_taken,
  input  logic [15:0] actual_target,
  input  logic        mispredict,
  output logic        predicted_taken,
  output logic [15:0] predicted_target,
  output logic [15:0] update_count,
  output logic [15:0] mispredict_count
);

  localparam logic [1:0]  CTR_RESET  = 2'b01;
  localparam logic [1:0]  CTR_WEAK_T = 2'b10;
  localparam logic [15:0] STAT_MAX   = 16'hFFFF;

  logic [1:0]  counter [ENTRIES];
  logic [15:0] target  [ENTRIES];

  logic [2:0]  lookup_idx;
  logic [2:0]  update_idx;
  logic [1:0]  update_ctr;
  logic [1:0]  next_ctr;
  logic        lookup_taken;

  assign lookup_idx = PC_curr[3:1];
  assign update_idx = IF_ID_PC_curr[3:1];
  assign update_ctr = counter[update_idx];

`ifdef BPU_TAG_CHECK_EN
  logic        valid [ENTRIES];
  logic [11:0] tag   [ENTRIES];
  logic        lookup_hit;
  logic        update_tag_match;

  assign lookup_hit       = valid[lookup_idx] && (tag[lookup_idx] == PC_curr[15:4]);
  assign update_tag_match = (tag[update_idx] == IF_ID_PC_curr[15:4]);
  assign lookup_taken     = counter[lookup_idx][1] && lookup_hit;
`else
  assign lookup_taken     = counter[lookup_idx][1];
`endif

  // Saturating 2-bit step; with tag checking a foreign entry is re-seeded weak.
  always_comb begin
    next_ctr = update_ctr;
    if (actual_taken) begin
      if (update_ctr != 2'b11) next_ctr = update_ctr + 2'd1;
    end else begin
      if (update_ctr != 2'b00) next_ctr = update_ctr - 2'd1;
    end
`ifdef BPU_TAG_CHECK_EN
    if (!update_tag_match) next_ctr = actual_taken ? CTR_WEAK_T : CTR_RESET;
`endif
  end

  // Lookup reads the registered arrays directly, so same-cycle updates are not bypassed.
  assign predicted_taken  = lookup_taken;
  assign predicted_target = lookup_taken ? target[lookup_idx] : 16'h0000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        counter[i] <= CTR_RESET;
        target[i]  <= 16'h0000;
      end
    end else begin
      if (wen_BHT) counter[update_idx] <= next_ctr;
      if (wen_BTB) target[update_idx]  <= actual_target;
    end
  end

`ifdef BPU_TAG_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        tag[i]   <= 12'h000;
      end
    end else if (wen_BTB) begin
      valid[update_idx] <= 1'b1;
      tag[update_idx]   <= IF_ID_PC_curr[15:4];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      update_count     <= 16'h0000;
      mispredict_count <= 16'h0000;
    end else begin
      if (wen_BHT && (update_count != STAT_MAX))
        update_count <= update_count + 16'd1;
      if (mispredict && (mispredict_count != STAT_MAX))
        mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_unit.sv
// ============================================================================
// Module   : tb_branch_predictor_unit
// Brief    : Directed self-checking bench for branch_predictor_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] PC_curr;
  logic [15:0] IF_ID_PC_curr;
  logic        wen_BHT;
  logic        wen_BTB;
  logic        actual_taken;
  logic [15:0] actual_target;
  logic        mispredict;
  logic        predicted_taken;
  logic [15:0] predicted_target;
  logic [15:0] update_count;
  logic [15:0] mispredict_count;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .PC_curr          (PC_curr),
    .IF_ID_PC_curr    (IF_ID_PC_curr),
    .wen_BHT          (wen_BHT),
    .wen_BTB          (wen_BTB),
    .actual_taken     (actual_taken),
    .actual_target    (actual_target),
    .mispredict       (mispredict),
    .predicted_taken  (predicted_taken),
    .predicted_target (predicted_target),
    .update_count     (update_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen_BHT = 1'b0;
    wen_BTB = 1'b0;
    mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One BHT update (optionally with BTB write) at pc, then return to idle.
  task automatic train(input logic [15:0] pc, input logic taken,
                       input logic btb, input logic [15:0] tgt);
    IF_ID_PC_curr = pc;
    actual_taken  = taken;
    actual_target = tgt;
    wen_BHT = 1'b1;
    wen_BTB = btb;
    tick();
    idle();
    #1;
  endtask

  task automatic look(input logic [15:0] pc);
    PC_curr = pc;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    PC_curr = 16'h0000;
    IF_ID_PC_curr = 16'h0000;
    actual_taken = 1'b0;
    actual_target = 16'h0000;
    idle();
    do_reset();

    // Reset state
    look(16'h0006);
    check("rst_taken",   predicted_taken,  1'b0);
    check("rst_target",  predicted_target, 16'h0000);
    check("rst_upd_cnt", update_count,     16'h0000);
    check("rst_mis_cnt", mispredict_count, 16'h0000);
    look(16'h000E);
    check("rst_taken_e", predicted_taken,  1'b0);

    // First taken update with target write
    train(16'h0006, 1'b1, 1'b1, 16'h0040);
    look(16'h0006);
    check("trn_taken",   predicted_taken,  1'b1);
    check("trn_target",  predicted_target, 16'h0040);
    check("trn_upd_cnt", update_count,     16'h0001);

    // Aliasing PC with the same index
    look(16'h0016);
`ifdef BPU_TAG_CHECK_EN
    check("alias_taken",  predicted_taken,  1'b0);
    check("alias_target", predicted_target, 16'h0000);
`else
    check("alias_taken",  predicted_taken,  1'b1);
    check("alias_target", predicted_target, 16'h0040);
`endif

    // Other entries untouched
    look(16'h0008);
    check("other_taken",  predicted_taken,  1'b0);
    check("other_target", predicted_target, 16'h0000);

    // BTB-only write leaves the counter alone; a later BHT update exposes it
    IF_ID_PC_curr = 16'h0002;
    actual_target = 16'h1234;
    wen_BTB = 1'b1;
    tick();
    idle();
    look(16'h0002);
    check("btb_only_taken", predicted_taken,  1'b0);
    check("btb_only_tgt",   predicted_target, 16'h0000);
    check("btb_only_upd",   update_count,     16'h0001);
    train(16'h0002, 1'b1, 1'b0, 16'h0000);
    look(16'h0002);
    check("btb_bht_taken",  predicted_taken,  1'b1);
    check("btb_bht_tgt",    predicted_target, 16'h1234);

    // Saturation up to 11 and back down to 00
    do_reset();
    look(16'h0006);
    for (int i = 0; i < 4; i++) begin
      train(16'h0006, 1'b1, 1'b0, 16'h0000);
      check($sformatf("sat_up_%0d", i), predicted_taken, 1'b1);
    end
    train(16'h0006, 1'b0, 1'b0, 16'h0000);
    check("sat_dn_0", predicted_taken, 1'b1);
    train(16'h0006, 1'b0, 1'b0, 16'h0000);
    check("sat_dn_1", predicted_taken, 1'b0);
    train(16'h0006, 1'b0, 1'b0, 16'h0000);
    check("sat_dn_2", predicted_taken, 1'b0);
    check("sat_upd_cnt", update_count, 16'h0007);
    // From 00 one taken step only reaches 01
    train(16'h0006, 1'b1, 1'b0, 16'h0000);
    check("floor_step", predicted_taken, 1'b0);

    // Same-cycle lookup and update: no bypass
    do_reset();
    PC_curr = 16'h0006;
    IF_ID_PC_curr = 16'h0006;
    actual_taken = 1'b1;
    wen_BHT = 1'b1;
    #1;
    check("bypass_same", predicted_taken, 1'b0);
    tick();
    idle();
    #1;
    check("bypass_next", predicted_taken, 1'b1);

    // Misprediction counting and saturation of both statistics
    do_reset();
    mispredict = 1'b1;
    tick();
    tick();
    tick();
    check("mis_cnt_3", mispredict_count, 16'h0003);
    check("upd_cnt_0", update_count,     16'h0000);
    wen_BHT = 1'b1;
    IF_ID_PC_curr = 16'h000A;
    actual_taken = 1'b1;
    for (int i = 3; i < 70000; i++) tick();
    check("mis_cnt_sat", mispredict_count, 16'hFFFF);
    check("upd_cnt_sat", update_count,     16'hFFFF);

    // Reset overrides concurrent writes
    rst_n = 1'b0;
    wen_BTB = 1'b1;
    actual_target = 16'hBEEF;
    tick();
    check("rst_ovr_mis", mispredict_count, 16'h0000);
    check("rst_ovr_upd", update_count,     16'h0000);
    look(16'h000A);
    check("rst_ovr_taken", predicted_taken,  1'b0);
    check("rst_ovr_tgt",   predicted_target, 16'h0000);
    rst_n = 1'b1;
    idle();
    tick();
    check("post_rst_mis", mispredict_count, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
